// File: rtl/uart_prog_loader.sv
// ============================================================================
// Module  : uart_prog_loader
// Brief   : Command parser behind uart_rx; loads program memory, gates CPU halt.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module uart_prog_loader #(
  parameter int                    DATA_WIDTH       = 8,
  parameter int                    ADDR_WIDTH       = 5,
  parameter int                    TIMEOUT_CYCLES   = 52100,
  parameter int                    TIMEOUT_BITWIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] CMD_LOAD         = 8'h4C,
  parameter logic [DATA_WIDTH-1:0] CMD_RUN          = 8'h52,
  parameter logic [DATA_WIDTH-1:0] CMD_HALT         = 8'h48
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_strb_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  cpu_halt_o,
  output logic                  busy_o,
  output logic                  done_strb_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  localparam logic [TIMEOUT_BITWIDTH-1:0] c_tmo_last = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_BITWIDTH-1:0] c_tmo_one  = TIMEOUT_BITWIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]       c_addr_one = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]       c_cnt_one  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]       c_zero     = '0;

  state_t                      r_state;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [DATA_WIDTH-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0]       r_chk;
  logic [TIMEOUT_BITWIDTH-1:0] r_tmo_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_chk       <= '0;
      r_tmo_cnt   <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_halt_o  <= 1'b1;
      busy_o      <= 1'b0;
      done_strb_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      mem_we_o    <= 1'b0;
      done_strb_o <= 1'b0;
      // A strobe always takes priority over an expiring timeout.
      if (rx_valid_strb_i) begin
        r_tmo_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (rx_data_i == CMD_LOAD) begin
              r_state    <= ST_ADDR;
              busy_o     <= 1'b1;
              err_o      <= 1'b0;
              cpu_halt_o <= 1'b1;
              r_chk      <= '0;
            end else if (rx_data_i == CMD_RUN) begin
              cpu_halt_o <= 1'b0;
            end else if (rx_data_i == CMD_HALT) begin
              cpu_halt_o <= 1'b1;
            end
          end
          ST_ADDR: begin
            r_addr  <= rx_data_i[ADDR_WIDTH-1:0];
            r_chk   <= r_chk ^ rx_data_i;
            r_state <= ST_LEN;
          end
          ST_LEN: begin
            r_cnt   <= rx_data_i;
            r_chk   <= r_chk ^ rx_data_i;
            r_state <= (rx_data_i != c_zero) ? ST_DATA : ST_CHK;
          end
          ST_DATA: begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= r_addr;
            mem_wdata_o <= rx_data_i;
            r_addr      <= r_addr + c_addr_one;
            r_chk       <= r_chk ^ rx_data_i;
            r_cnt       <= r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) begin
              r_state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (rx_data_i == r_chk) begin
              done_strb_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
            r_state <= ST_IDLE;
            busy_o  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_tmo_cnt == c_tmo_last) begin
          r_state   <= ST_IDLE;
          busy_o    <= 1'b0;
          err_o     <= 1'b1;
          r_tmo_cnt <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
// ============================================================================
// Module  : tb_uart_prog_loader
// Brief   : Directed vector bench for uart_prog_loader.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_uart_prog_loader;

  localparam int TMO = 60;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_strb_i;
  logic       mem_we_o;
  logic [4:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic       cpu_halt_o;
  logic       busy_o;
  logic       done_strb_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  uart_prog_loader #(
    .DATA_WIDTH       (8),
    .ADDR_WIDTH       (5),
    .TIMEOUT_CYCLES   (TMO),
    .TIMEOUT_BITWIDTH (16)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .rx_data_i       (rx_data_i),
    .rx_valid_strb_i (rx_valid_strb_i),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .cpu_halt_o      (cpu_halt_o),
    .busy_o          (busy_o),
    .done_strb_o     (done_strb_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (done_strb_o) done_cnt++;

  typedef struct {
    logic [7:0] data;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wd;
    logic       halt;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic we, input logic [4:0] a, input logic [7:0] wd,
                     input logic halt, input logic busy, input logic done, input logic err);
    vec_t v;
    v.data = d; v.we = we; v.addr = a; v.wd = wd;
    v.halt = halt; v.busy = busy; v.done = done; v.err = err;
    tbl.push_back(v);
  endtask

  // Strobe one byte; outputs are sampled 1 time unit after the consuming edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk_i);
    rx_data_i       = b;
    rx_valid_strb_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_strb_i = 1'b0;
  endtask

  task automatic pulse_gone(input string name);
    @(posedge clk_i);
    #1;
    check({name, " we_pulse"},   {31'd0, mem_we_o},    32'd0);
    check({name, " done_pulse"}, {31'd0, done_strb_o}, 32'd0);
  endtask

  initial begin
    int d0;
    reset_i         = 1'b1;
    rx_data_i       = 8'h00;
    rx_valid_strb_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst halt", {31'd0, cpu_halt_o}, 32'd1);
    check("rst err",  {31'd0, err_o},      32'd0);
    check("rst busy", {31'd0, busy_o},     32'd0);
    check("rst we",   {31'd0, mem_we_o},   32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    //   data   we  addr   wd     halt busy done err
    add(8'h52, 0, 5'd0,  8'h00, 0, 0, 0, 0);
    add(8'h48, 0, 5'd0,  8'h00, 1, 0, 0, 0);
    add(8'h4C, 0, 5'd0,  8'h00, 1, 1, 0, 0);
    add(8'h03, 0, 5'd0,  8'h00, 1, 1, 0, 0);
    add(8'h02, 0, 5'd0,  8'h00, 1, 1, 0, 0);
    add(8'hA1, 1, 5'd3,  8'hA1, 1, 1, 0, 0);
    add(8'hB2, 1, 5'd4,  8'hB2, 1, 1, 0, 0);
    add(8'h12, 0, 5'd4,  8'hB2, 1, 0, 1, 0);
    add(8'h52, 0, 5'd4,  8'hB2, 0, 0, 0, 0);
    add(8'h4C, 0, 5'd4,  8'hB2, 1, 1, 0, 0);
    add(8'h1F, 0, 5'd4,  8'hB2, 1, 1, 0, 0);
    add(8'h02, 0, 5'd4,  8'hB2, 1, 1, 0, 0);
    add(8'h11, 1, 5'd31, 8'h11, 1, 1, 0, 0);
    add(8'h22, 1, 5'd0,  8'h22, 1, 1, 0, 0);
    add(8'h1F ^ 8'h02 ^ 8'h11 ^ 8'h22, 0, 5'd0, 8'h22, 1, 0, 1, 0);
    add(8'h4C, 0, 5'd0,  8'h22, 1, 1, 0, 0);
    add(8'h05, 0, 5'd0,  8'h22, 1, 1, 0, 0);
    add(8'h01, 0, 5'd0,  8'h22, 1, 1, 0, 0);
    add(8'h77, 1, 5'd5,  8'h77, 1, 1, 0, 0);
    add(8'h00, 0, 5'd5,  8'h77, 1, 0, 0, 1);
    add(8'h52, 0, 5'd5,  8'h77, 0, 0, 0, 1);
    add(8'h4C, 0, 5'd5,  8'h77, 1, 1, 0, 0);
    add(8'h05, 0, 5'd5,  8'h77, 1, 1, 0, 0);
    add(8'h00, 0, 5'd5,  8'h77, 1, 1, 0, 0);
    add(8'h05, 0, 5'd5,  8'h77, 1, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      string n;
      n = $sformatf("v%0d", i);
      send(tbl[i].data);
      check({n, " we"},    {31'd0, mem_we_o},    {31'd0, tbl[i].we});
      check({n, " addr"},  {27'd0, mem_addr_o},  {27'd0, tbl[i].addr});
      check({n, " wdata"}, {24'd0, mem_wdata_o}, {24'd0, tbl[i].wd});
      check({n, " halt"},  {31'd0, cpu_halt_o},  {31'd0, tbl[i].halt});
      check({n, " busy"},  {31'd0, busy_o},      {31'd0, tbl[i].busy});
      check({n, " done"},  {31'd0, done_strb_o}, {31'd0, tbl[i].done});
      check({n, " err"},   {31'd0, err_o},       {31'd0, tbl[i].err});
      pulse_gone(n);
    end

    // Timeout: last byte consumed at edge E0, state must drop exactly at edge E_TMO.
    send(8'h4C);
    pulse_gone("tmo L");
    send(8'h05);
    d0 = done_cnt;
    repeat (TMO - 1) @(posedge clk_i);
    #1;
    check("tmo busy before", {31'd0, busy_o}, 32'd1);
    check("tmo err before",  {31'd0, err_o},  32'd0);
    @(posedge clk_i);
    #1;
    check("tmo busy after", {31'd0, busy_o}, 32'd0);
    check("tmo err after",  {31'd0, err_o},  32'd1);
    check("tmo no done",    done_cnt,        d0);

    // A strobe on the very timeout edge is processed instead of timing out.
    send(8'h4C);
    pulse_gone("race L");
    repeat (TMO - 2) @(posedge clk_i);
    send(8'h09);
    check("race busy", {31'd0, busy_o}, 32'd1);
    check("race err",  {31'd0, err_o},  32'd0);
    send(8'h00);
    send(8'h09);
    check("race done", {31'd0, done_strb_o}, 32'd1);
    check("race err2", {31'd0, err_o},       32'd0);

    // Asynchronous reset in the middle of the data phase.
    send(8'h52);
    send(8'h4C);
    send(8'h00);
    send(8'h03);
    send(8'hAA);
    check("mid we", {31'd0, mem_we_o}, 32'd1);
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("mr we",    {31'd0, mem_we_o},    32'd0);
    check("mr addr",  {27'd0, mem_addr_o},  32'd0);
    check("mr wdata", {24'd0, mem_wdata_o}, 32'd0);
    check("mr halt",  {31'd0, cpu_halt_o},  32'd1);
    check("mr busy",  {31'd0, busy_o},      32'd0);
    check("mr done",  {31'd0, done_strb_o}, 32'd0);
    check("mr err",   {31'd0, err_o},       32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    send(8'h00);
    check("ign halt", {31'd0, cpu_halt_o}, 32'd1);
    check("ign busy", {31'd0, busy_o},     32'd0);
    send(8'h52);
    check("run halt", {31'd0, cpu_halt_o}, 32'd0);
    check("run busy", {31'd0, busy_o},     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
